// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t     : FSM state encoding (IDLE / SHIFT / DONE)
//   BIN_W_DEF   : default binary input width
//   DIGITS_DEF  : default number of BCD output digits
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int BIN_W_DEF  = 8;
  localparam int DIGITS_DEF = 3;

endpackage : bcd_pkg

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction: a BCD digit that is 5 or more gets 3
// added so that the following left shift carries into the next digit.
//   d : 4-bit scratch digit in
//   q : corrected 4-bit digit out
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd5) q = 4'(d + 4'd3);
  end

endmodule : bcd_add3

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   clk, rst_n : clock, async active-low reset
//   start, bin : conversion request and operand, sampled only in IDLE
//   busy       : high while shifting (BIN_W cycles)
//   done       : one-cycle pulse when bcd holds a fresh result
//   bcd        : packed BCD result, digit 0 in [3:0], held until next result
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd
);

  localparam int SCR_W = DIGITS * 4;
  localparam int SR_W  = SCR_W + BIN_W;
  // One extra count value so the increment on the final iteration cannot wrap.
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  // {scratch digits, remaining binary bits}
  logic [SR_W-1:0]    sr_q,    sr_d;
  logic [SCR_W-1:0]   bcd_q,   bcd_d;

  logic [SCR_W-1:0]   scr_adj;
  logic [SR_W-1:0]    sr_cat;
  logic [SR_W-1:0]    sr_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_add3 u_add3 (
      .d (sr_q[BIN_W + 4*g +: 4]),
      .q (scr_adj[4*g +: 4])
    );
  end

  // Correct first, then shift the whole {scratch, binary} word left by one.
  always_comb begin
    sr_cat   = {scr_adj, sr_q[BIN_W-1:0]};
    sr_shift = sr_cat << 1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    bcd_d   = bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d    = {{SCR_W{1'b0}}, bin};
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d  = sr_shift;
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          // Publish straight from the final shift so bcd is valid in DONE.
          bcd_d   = sr_shift[SR_W-1 -: SCR_W];
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      bcd_q   <= bcd_d;
    end
  end

  // Decoded straight from state so reset clears them without a clock.
  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign bcd  = bcd_q;

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq (default BIN_W=8, DIGITS=3).
// Expected results come from a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  bin = 8'h00;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int checks = 0;
  int failures = 0;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits by plain division.
  function automatic logic [11:0] model(input int v);
    int h, t, o;
    h = (v / 100) % 10;
    t = (v / 10) % 10;
    o = v % 10;
    return 12'((h << 8) | (t << 4) | o);
  endfunction

  // Stimulus driver: issues one request and observes the following cycles.
  // n counts edges from the accepting edge (n=1); outputs sampled on negedge.
  task automatic do_conv(input logic [7:0] v, input bit chg_bin,
                         output int lat, output int busy_cnt, output int done_cnt,
                         output logic [11:0] res, output int hold_bad, output int overlap);
    logic [11:0] prev;
    lat = 0; busy_cnt = 0; done_cnt = 0; res = 'x; hold_bad = 0; overlap = 0;
    @(negedge clk);
    bin = v; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    prev = bcd;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (chg_bin) bin = 8'($urandom);
      if (busy) begin
        busy_cnt++;
        if (bcd !== prev) hold_bad++;
      end
      if (busy && done) overlap++;
      if (done) begin
        done_cnt++;
        if (lat == 0) lat = n;
        res = bcd;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (bcd !== 12'h000) begin failures++; $display("FAIL reset_bcd got=%h exp=000", bcd); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [7:0] vals [4] = '{8'h00, 8'hFF, 8'h63, 8'h0A};
    int lat, bc, dc, hb, ov;
    logic [11:0] res;
    for (int i = 0; i < 4; i++) begin
      do_conv(vals[i], 1'b0, lat, bc, dc, res, hb, ov);
      checks++; if (res !== model(vals[i])) begin failures++; $display("FAIL dir_bcd in=%h got=%h exp=%h", vals[i], res, model(vals[i])); end
      checks++; if (lat !== 9) begin failures++; $display("FAIL dir_latency in=%h got=%0d exp=9", vals[i], lat); end
      checks++; if (bc !== 8) begin failures++; $display("FAIL dir_busy_cycles in=%h got=%0d exp=8", vals[i], bc); end
      checks++; if (dc !== 1) begin failures++; $display("FAIL dir_done_pulses in=%h got=%0d exp=1", vals[i], dc); end
      checks++; if (hb !== 0) begin failures++; $display("FAIL dir_bcd_hold in=%h got=%0d exp=0", vals[i], hb); end
      checks++; if (ov !== 0) begin failures++; $display("FAIL dir_busy_done_overlap in=%h got=%0d exp=0", vals[i], ov); end
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0, cyc = 0, last = 0, badd;
    @(negedge clk);
    bin = 8'h00; start = 1'b1;
    while (idx < 256 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        checks++; if (bcd !== model(idx)) begin failures++; $display("FAIL b2b_bcd in=%0d got=%h exp=%h", idx, bcd, model(idx)); end
        badd = 0;
        for (int d = 0; d < 3; d++) if (bcd[4*d +: 4] > 4'd9) badd++;
        checks++; if (badd !== 0) begin failures++; $display("FAIL b2b_digit_range in=%0d got=%h", idx, bcd); end
        if (idx > 0) begin
          checks++; if (cyc - last !== 10) begin failures++; $display("FAIL b2b_period in=%0d got=%0d exp=10", idx, cyc - last); end
        end
        last = cyc;
        idx++;
        bin = 8'(idx);
      end
    end
    start = 1'b0;
    checks++; if (idx !== 256) begin failures++; $display("FAIL b2b_timeout got=%0d exp=256", idx); end
  endtask

  task automatic test_start_ignored();
    int dn = 0, extra = 0;
    logic [11:0] res = 'x;
    @(negedge clk);
    bin = 8'h2A; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 3) begin start = 1'b1; bin = 8'h11; end
      else if (n == 4) start = 1'b0;
      if (done) begin dn++; res = bcd; end
      if (n > 10 && busy) extra++;
    end
    checks++; if (res !== 12'h042) begin failures++; $display("FAIL ign_bcd got=%h exp=042", res); end
    checks++; if (dn !== 1) begin failures++; $display("FAIL ign_done_pulses got=%0d exp=1", dn); end
    checks++; if (extra !== 0) begin failures++; $display("FAIL ign_second_conv got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_abort();
    int seen = 0, lat, bc, dc, hb, ov;
    logic [11:0] res;
    @(negedge clk);
    bin = 8'hC8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 4; n++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
    checks++; if (bcd !== 12'h000) begin failures++; $display("FAIL abort_bcd got=%h exp=000", bcd); end
    for (int n = 0; n < 3; n++) begin @(negedge clk); if (done || busy) seen++; end
    rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin @(negedge clk); if (done || busy) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL abort_activity got=%0d exp=0", seen); end
    do_conv(8'h07, 1'b0, lat, bc, dc, res, hb, ov);
    checks++; if (res !== 12'h007) begin failures++; $display("FAIL abort_next_bcd got=%h exp=007", res); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL abort_next_latency got=%0d exp=9", lat); end
  endtask

  task automatic test_bin_change();
    int lat, bc, dc, hb, ov;
    logic [11:0] res;
    do_conv(8'h80, 1'b1, lat, bc, dc, res, hb, ov);
    checks++; if (res !== 12'h128) begin failures++; $display("FAIL binchg_bcd got=%h exp=128", res); end
    checks++; if (dc !== 1) begin failures++; $display("FAIL binchg_done_pulses got=%0d exp=1", dc); end
  endtask

  task automatic test_random();
    int lat, bc, dc, hb, ov;
    logic [11:0] res;
    logic [7:0] v;
    for (int i = 0; i < 20; i++) begin
      v = 8'($urandom_range(0, 255));
      do_conv(v, 1'b0, lat, bc, dc, res, hb, ov);
      checks++; if (res !== model(v)) begin failures++; $display("FAIL rnd_bcd in=%h got=%h exp=%h", v, res, model(v)); end
      checks++; if (lat !== 9 || dc !== 1 || bc !== 8) begin failures++; $display("FAIL rnd_timing in=%h lat=%0d done=%0d busy=%0d exp=9/1/8", v, lat, dc, bc); end
      checks++; if (hb !== 0 || ov !== 0) begin failures++; $display("FAIL rnd_hold in=%h hold=%0d overlap=%0d exp=0/0", v, hb, ov); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_ignored();
    test_reset_abort();
    test_bin_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bin2bcd_seq
